// File: rtl/motion_bbox_extract_pkg.sv
// Shared widths, descriptor layout, FSM states and descriptor packing for motion_bbox_extract.
package bbox_pkg;

   localparam int X_W      = 11;
   localparam int Y_W      = 10;
   localparam int CNT_W    = 20;
   localparam int DESC_W   = 43;
   localparam int FLAG_BIT = 42;
   localparam int YMAX_LSB = 32;
   localparam int XMAX_LSB = 21;
   localparam int YMIN_LSB = 11;
   localparam int XMIN_LSB = 0;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FRAME = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   // A cleared flag forces every coordinate field to zero.
   function automatic logic [DESC_W-1:0] pack_desc(
      input logic           flag,
      input logic [Y_W-1:0] ymax,
      input logic [X_W-1:0] xmax,
      input logic [Y_W-1:0] ymin,
      input logic [X_W-1:0] xmin
   );
      logic [DESC_W-1:0] d;
      d = {DESC_W{1'b0}};
      if (flag) begin
         d[FLAG_BIT]          = 1'b1;
         d[YMAX_LSB +: Y_W]   = ymax;
         d[XMAX_LSB +: X_W]   = xmax;
         d[YMIN_LSB +: Y_W]   = ymin;
         d[XMIN_LSB +: X_W]   = xmin;
      end else begin
         d = {DESC_W{1'b0}};
      end
      return d;
   endfunction

endpackage

// File: rtl/motion_bbox_extract_if.sv
// Mask pixel stream in, per-frame target descriptors out.
interface motion_bbox_extract_if;
   import bbox_pkg::*;

   logic              per_frame_vsync;
   logic              per_frame_href;
   logic              per_frame_clken;
   logic              per_img_bit;
   logic [DESC_W-1:0] target_pos_out1;
   logic [DESC_W-1:0] target_pos_out2;
   logic              target_pos_valid;

   modport master (
      output per_frame_vsync, per_frame_href, per_frame_clken, per_img_bit,
      input  target_pos_out1, target_pos_out2, target_pos_valid
   );

   modport slave (
      input  per_frame_vsync, per_frame_href, per_frame_clken, per_img_bit,
      output target_pos_out1, target_pos_out2, target_pos_valid
   );

endinterface

// File: rtl/motion_bbox_extract_accum.sv
// Min/max/count tracker for one column region; a clear coinciding with a hit loads that pixel.
module bbox_accum
   import bbox_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             hit,
   input  logic [X_W-1:0]   x,
   input  logic [Y_W-1:0]   y,
   output logic [X_W-1:0]   xmin_r,
   output logic [X_W-1:0]   xmax_r,
   output logic [Y_W-1:0]   ymin_r,
   output logic [Y_W-1:0]   ymax_r,
   output logic [CNT_W-1:0] cnt_r
);

   // Accumulate extents and a saturating pixel count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xmin_r <= {X_W{1'b0}};
         xmax_r <= {X_W{1'b0}};
         ymin_r <= {Y_W{1'b0}};
         ymax_r <= {Y_W{1'b0}};
         cnt_r  <= {CNT_W{1'b0}};
      end else if (hit) begin
         if (clr || (cnt_r == {CNT_W{1'b0}})) begin
            xmin_r <= x;
            xmax_r <= x;
            ymin_r <= y;
            ymax_r <= y;
            cnt_r  <= {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            if (x < xmin_r) xmin_r <= x;
            if (x > xmax_r) xmax_r <= x;
            if (y < ymin_r) ymin_r <= y;
            if (y > ymax_r) ymax_r <= y;
            if (cnt_r != {CNT_W{1'b1}}) cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end else if (clr) begin
         xmin_r <= {X_W{1'b0}};
         xmax_r <= {X_W{1'b0}};
         ymin_r <= {Y_W{1'b0}};
         ymax_r <= {Y_W{1'b0}};
         cnt_r  <= {CNT_W{1'b0}};
      end
   end

endmodule

// File: rtl/motion_bbox_extract.sv
// Per-frame two-region bounding-box extractor; results of frame N are published at its vsync fall.
// Optional box expansion and clamping is enabled by defining BBOX_MARGIN_EN.
module motion_bbox_extract
   import bbox_pkg::*;
#(
   parameter int IMG_HDISP = 1280,
   parameter int IMG_VDISP = 720,
   parameter int SPLIT_X   = 640,
   parameter int MIN_PIX   = 64,
   parameter int MARGIN_X  = 50,
   parameter int MARGIN_Y  = 20
) (
   input  logic                 clk,
   input  logic                 rst_n,
   motion_bbox_extract_if.slave bus
);

   localparam logic [X_W-1:0]   HMAX    = X_W'(IMG_HDISP - 1);
   localparam logic [X_W-1:0]   SPLIT_V = X_W'(SPLIT_X);
   localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PIX);
`ifdef BBOX_MARGIN_EN
   localparam logic [Y_W-1:0]   VMAX    = Y_W'(IMG_VDISP - 1);
   localparam logic [X_W-1:0]   MX      = X_W'(MARGIN_X);
   localparam logic [Y_W-1:0]   MY      = Y_W'(MARGIN_Y);
`endif

   function automatic logic [DESC_W-1:0] make_desc(
      input logic [CNT_W-1:0] cnt,
      input logic [X_W-1:0]   xmin, xmax,
      input logic [Y_W-1:0]   ymin, ymax
   );
      logic           flag;
      logic [X_W-1:0] xlo, xhi;
      logic [Y_W-1:0] ylo, yhi;
      flag = (cnt >= MIN_CNT);
`ifdef BBOX_MARGIN_EN
      xlo = (xmin > MX) ? (xmin - MX) : {X_W{1'b0}};
      xhi = (xmax < (HMAX - MX)) ? (xmax + MX) : HMAX;
      ylo = (ymin > MY) ? (ymin - MY) : {Y_W{1'b0}};
      yhi = (ymax < (VMAX - MY)) ? (ymax + MY) : VMAX;
`else
      xlo = xmin;
      xhi = xmax;
      ylo = ymin;
      yhi = ymax;
`endif
      return pack_desc(flag, yhi, xhi, ylo, xlo);
   endfunction

   state_t            state_r;
   logic              vsync_d_r;
   logic              rise_pend_r;
   logic [X_W-1:0]    x_r;
   logic [Y_W-1:0]    y_r;
   logic [DESC_W-1:0] out1_r, out2_r;
   logic              valid_r;

   logic              rise_s, fall_s, start_s, fg_s, left_s;
   logic [DESC_W-1:0] desc1_s, desc2_s;
   logic [X_W-1:0]    xmin1_s, xmax1_s, xmin2_s, xmax2_s;
   logic [Y_W-1:0]    ymin1_s, ymax1_s, ymin2_s, ymax2_s;
   logic [CNT_W-1:0]  cnt1_s, cnt2_s;
   logic              unused_s;

   assign unused_s = ^{bus.per_frame_href, IMG_VDISP[0], MARGIN_X[0], MARGIN_Y[0]};

   // Edge detection, frame start and region split for the current pixel.
   always_comb begin
      rise_s  = bus.per_frame_vsync & ~vsync_d_r;
      fall_s  = ~bus.per_frame_vsync & vsync_d_r;
      start_s = (state_r == S_IDLE) & (rise_s | rise_pend_r);
      fg_s    = bus.per_frame_vsync & bus.per_frame_clken & bus.per_img_bit &
                (start_s | (state_r == S_FRAME));
      left_s  = (x_r < SPLIT_V);
      desc1_s = make_desc(cnt1_s, xmin1_s, xmax1_s, ymin1_s, ymax1_s);
      desc2_s = make_desc(cnt2_s, xmin2_s, xmax2_s, ymin2_s, ymax2_s);
   end

   // Raster position; x also returns to 0 on any cycle without a pixel strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_r <= {X_W{1'b0}};
         y_r <= {Y_W{1'b0}};
      end else if (!bus.per_frame_vsync) begin
         x_r <= {X_W{1'b0}};
         y_r <= {Y_W{1'b0}};
      end else if (bus.per_frame_clken) begin
         if (x_r < HMAX) begin
            x_r <= x_r + {{(X_W-1){1'b0}}, 1'b1};
         end else begin
            x_r <= {X_W{1'b0}};
            y_r <= y_r + {{(Y_W-1){1'b0}}, 1'b1};
         end
      end else begin
         x_r <= {X_W{1'b0}};
      end
   end

   // Frame FSM with registered results. vsync_d resets high so a frame already running at reset release is skipped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= S_IDLE;
         vsync_d_r   <= 1'b1;
         rise_pend_r <= 1'b0;
         out1_r      <= {DESC_W{1'b0}};
         out2_r      <= {DESC_W{1'b0}};
         valid_r     <= 1'b0;
      end else begin
         vsync_d_r <= bus.per_frame_vsync;
         case (state_r)
            S_IDLE: begin
               valid_r     <= 1'b0;
               rise_pend_r <= 1'b0;
               if (start_s) state_r <= S_FRAME;
            end
            S_FRAME: begin
               valid_r <= 1'b0;
               if (fall_s) state_r <= S_DONE;
            end
            S_DONE: begin
               out1_r      <= desc1_s;
               out2_r      <= desc2_s;
               valid_r     <= 1'b1;
               rise_pend_r <= rise_s;
               state_r     <= S_IDLE;
            end
            default: begin
               valid_r     <= 1'b0;
               rise_pend_r <= 1'b0;
               state_r     <= S_IDLE;
            end
         endcase
      end
   end

   bbox_accum u_acc_left (
      .clk(clk), .rst_n(rst_n), .clr(start_s), .hit(fg_s & left_s),
      .x(x_r), .y(y_r),
      .xmin_r(xmin1_s), .xmax_r(xmax1_s), .ymin_r(ymin1_s), .ymax_r(ymax1_s), .cnt_r(cnt1_s)
   );

   bbox_accum u_acc_right (
      .clk(clk), .rst_n(rst_n), .clr(start_s), .hit(fg_s & ~left_s),
      .x(x_r), .y(y_r),
      .xmin_r(xmin2_s), .xmax_r(xmax2_s), .ymin_r(ymin2_s), .ymax_r(ymax2_s), .cnt_r(cnt2_s)
   );

   assign bus.target_pos_out1  = out1_r;
   assign bus.target_pos_out2  = out2_r;
   assign bus.target_pos_valid = valid_r;

endmodule

// File: tb/tb_motion_bbox_extract.sv
// Directed table-driven bench for motion_bbox_extract; expectations follow BBOX_MARGIN_EN when defined.
module tb_motion_bbox_extract;

   localparam int HD = 1280;

   typedef struct {
      int          x0, x1, y0, y1;
      int          ncyc;
      logic [42:0] e1, e2;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;
   vec_t tbl [8];

   motion_bbox_extract_if bus ();

   motion_bbox_extract dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   function automatic logic [42:0] mk(input int flag, input int ymax, input int xmax,
                                      input int ymin, input int xmin);
      int a, b, c, d;
      a = ymax; b = xmax; c = ymin; d = xmin;
      if (flag == 0) return 43'd0;
`ifdef BBOX_MARGIN_EN
      c = (ymin > 20) ? ymin - 20 : 0;
      a = (ymax < 699) ? ymax + 20 : 719;
      d = (xmin > 50) ? xmin - 50 : 0;
      b = (xmax < 1229) ? xmax + 50 : 1279;
`endif
      return {1'b1, 10'(a), 11'(b), 10'(c), 11'(d)};
   endfunction

   task automatic check(input string name, input logic [42:0] act, input logic [42:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Low gap with stray pixels (must be ignored), then ncyc continuous pixels, then vsync falls.
   task automatic run_frame(input vec_t v, input int idx);
      int px, py;
      @(negedge clk);
      bus.per_frame_vsync = 1'b0;
      bus.per_frame_clken = 1'b1;
      bus.per_img_bit     = 1'b1;
      repeat (3) @(negedge clk);
      bus.per_frame_vsync = 1'b1;
      bus.per_frame_href  = 1'b1;
      for (int i = 0; i < v.ncyc; i++) begin
         px = i % HD;
         py = i / HD;
         bus.per_img_bit = (px >= v.x0 && px <= v.x1 && py >= v.y0 && py <= v.y1);
         @(negedge clk);
      end
      bus.per_frame_vsync = 1'b0;
      bus.per_frame_href  = 1'b0;
      bus.per_frame_clken = 1'b0;
      bus.per_img_bit     = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d_valid_E0", idx), {42'd0, bus.target_pos_valid}, 43'd0);
      @(negedge clk);
      check($sformatf("v%0d_valid_E1", idx), {42'd0, bus.target_pos_valid}, 43'd1);
      check($sformatf("v%0d_out1", idx), bus.target_pos_out1, v.e1);
      check($sformatf("v%0d_out2", idx), bus.target_pos_out2, v.e2);
      @(negedge clk);
      check($sformatf("v%0d_valid_E2", idx), {42'd0, bus.target_pos_valid}, 43'd0);
      check($sformatf("v%0d_hold1", idx), bus.target_pos_out1, v.e1);
   endtask

   initial begin
      int vcount;
      tbl[0] = '{100, 199, 5, 14, 16*HD,     mk(1, 14, 199, 5, 100), mk(0, 0, 0, 0, 0)};
      tbl[1] = '{700, 762, 0, 0, HD,         mk(0, 0, 0, 0, 0),      mk(0, 0, 0, 0, 0)};
      tbl[2] = '{700, 763, 0, 0, HD,         mk(0, 0, 0, 0, 0),      mk(1, 0, 763, 0, 700)};
      tbl[3] = '{1, 0, 0, 0, HD,             mk(0, 0, 0, 0, 0),      mk(0, 0, 0, 0, 0)};
      tbl[4] = '{576, 703, 0, 0, HD,         mk(1, 0, 639, 0, 576),  mk(1, 0, 703, 0, 640)};
      tbl[5] = '{1200, 1279, 1, 3, 4*HD,     mk(0, 0, 0, 0, 0),      mk(1, 3, 1279, 1, 1200)};
      tbl[6] = '{100, 199, 0, 9, 5*HD + 150, mk(1, 5, 199, 0, 100),  mk(0, 0, 0, 0, 0)};
      tbl[7] = '{0, 63, 0, 0, 640,           mk(1, 0, 63, 0, 0),     mk(0, 0, 0, 0, 0)};

      rst_n               = 1'b0;
      bus.per_frame_vsync = 1'b0;
      bus.per_frame_href  = 1'b0;
      bus.per_frame_clken = 1'b0;
      bus.per_img_bit     = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_out1", bus.target_pos_out1, 43'd0);
      check("rst_out2", bus.target_pos_out2, 43'd0);
      check("rst_valid", {42'd0, bus.target_pos_valid}, 43'd0);
      rst_n = 1'b1;

      for (int k = 0; k < 8; k++) run_frame(tbl[k], k);

      // Reset in mid-frame, released while vsync is still high: that frame yields nothing.
      @(negedge clk);
      bus.per_frame_vsync = 1'b0;
      bus.per_frame_clken = 1'b1;
      bus.per_img_bit     = 1'b1;
      repeat (3) @(negedge clk);
      bus.per_frame_vsync = 1'b1;
      repeat (500) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_out1", bus.target_pos_out1, 43'd0);
      check("midrst_out2", bus.target_pos_out2, 43'd0);
      check("midrst_valid", {42'd0, bus.target_pos_valid}, 43'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (300) @(negedge clk);
      bus.per_frame_vsync = 1'b0;
      bus.per_frame_clken = 1'b0;
      bus.per_img_bit     = 1'b0;
      vcount = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus.target_pos_valid) vcount++;
      end
      check("midrst_no_valid", 43'(vcount), 43'd0);
      check("midrst_out1_kept", bus.target_pos_out1, 43'd0);

      run_frame(tbl[4], 8);
      run_frame(tbl[0], 9);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
